vec_lane_sched: RTL and testbench
=================================

Name: vec_lane_sched

Overview:
- Sequences up to four vec_alu lane instances for one vector ALU instruction.
- Accepts an instruction (opcode, op_type, vsew, vs1/vs2 operands) over a start/ready handshake, then derives the active lane count and run length.
- Drives per-lane run, gathers every lane's vd slice at its reg_index into one VLEN result, and checks the lanes' done flags.
- Sits between the vector decode stage and the vec_alu array.

Parameters:
- VLEN, 128, vector register width in bits.
- LANE_WIDTH, 5, log2 of lane datapath width (5 = 32-bit lanes).
- NB_LANES, 1, log2 of instantiated lane count; legal 0..2.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  instruction valid.
- ready  out  1  high in IDLE only; start accepted when start&&ready.
- opcode  in  6  ALU opcode (VADD 000000, VAND 001001, VOR 001010, VXOR 001011).
- op_type  in  3  VV 001, VX 010, VI 100.
- vsew  in  3  element width code 0..3 (8/16/32/64b).
- vs1_in, vs2_in  in  VLEN  operands.
- alu_opcode, alu_op_type, alu_vsew  out  6/3/3  registered copies broadcast to all lanes.
- alu_vs1, alu_vs2  out  VLEN  registered operands broadcast.
- alu_nb_lanes  out  2  log2 of active lanes.
- alu_run  out  4  per-lane run.
- alu_vd  in  4*VLEN  lane i result at [i*VLEN +: VLEN].
- alu_reg_index  in  40  lane i bit index at [i*10 +: 10].
- alu_done  in  4  per-lane done.
- vd  out  VLEN  assembled result; held until next accept.
- vd_valid  out  1  one-cycle pulse when vd is final.
- error  out  1  one-cycle pulse on illegal vsew or done protocol violation.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE, ready=1, alu_run=0, vd=0, vd_valid=0, error=0, all alu_* config regs 0. Applies mid-operation; lanes see run drop the next cycle.
- On accept, register opcode/op_type/vsew/vs1/vs2 and clear vd.
- Derived quantities:
  - E = min(VLEN>>(vsew+3), 1<<NB_LANES); nb = 0 if E=1, 1 if E in 2..3, 2 if E>=4.
  - Active mask = lanes i < (1<<nb); inactive lanes' run stays 0.
  - S = min(vsew+3, LANE_WIDTH); slice width W = 1<<S bits.
  - N = (VLEN>>S)>>nb run cycles.
- Illegal vsew (>=4) at accept: error pulses the next cycle, state stays IDLE, no run, vd unchanged.
- State IDLE: ready=1; on accept go to CFG.
- State CFG (1 cycle): alu_nb_lanes=nb and config valid, alu_run=0. Go to RUN with counter=N.
- State RUN (N cycles): alu_run=active mask; counter decrements each cycle; leave when it reaches 1 -> WAIT.
  - Capture: on every posedge where the previous cycle had alu_run[i]=1, copy alu_vd[i] bits [reg_index_i +: W] into vd at the same position. Per-lane W-bit mux; no other bits of vd change.
- State WAIT (1 cycle): alu_run=0; the final capture occurs.
  - All active alu_done must be 1; otherwise error pulses.
  - Next state DONE either way.
- State DONE (1 cycle): vd_valid=1, then IDLE.
- Protocol check: any active alu_done=1 during RUN gives an error pulse; sequencing continues.
- Latency: accept at edge T; vd_valid high in the cycle after edge T+N+3.
- start while not ready is ignored, with no queuing.
- reg_index values outside 0..VLEN-W are ignored (no capture for that lane).

Test Plan:
- VAND VV, vs1=all ones, vs2=128'h8765432112345678beefbeefabcdabcd, vsew=0, NB_LANES=1 -> nb=1, alu_run=0011 for exactly 8 cycles, vd=vs2, vd_valid 11 cycles after accept, error=0.
- VXOR VV, vs1=vs2=same value, vsew=2 -> N=2, vd=0, vd_valid 5 cycles after accept.
- vsew=3 (64b on 32b lanes), VOR VV with vs1=0 -> W=32, N=2, vd=vs2.
- vsew=5 at accept -> error pulse 1 cycle, alu_run never asserted, ready stays 1.
- Lane stub holds done=0 in WAIT -> error pulse coincident with WAIT, vd_valid still asserted next cycle.
- resetn low during RUN cycle 3 of a vsew=0 op -> next cycle alu_run=0, vd=0, ready=1; new op then completes correctly.

Source files
------------

// File: rtl/vec_lane_sched.sv
// Vector ALU lane sequencer: accepts one instruction, runs up to four vec_alu lanes in
// lock-step and gathers their per-lane result slices into a single VLEN-wide destination.
module vec_lane_sched #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 5,
    parameter int NB_LANES   = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              ready,
    input  logic [5:0]        opcode,
    input  logic [2:0]        op_type,
    input  logic [2:0]        vsew,
    input  logic [VLEN-1:0]   vs1_in,
    input  logic [VLEN-1:0]   vs2_in,
    output logic [5:0]        alu_opcode,
    output logic [2:0]        alu_op_type,
    output logic [2:0]        alu_vsew,
    output logic [VLEN-1:0]   alu_vs1,
    output logic [VLEN-1:0]   alu_vs2,
    output logic [1:0]        alu_nb_lanes,
    output logic [3:0]        alu_run,
    input  logic [4*VLEN-1:0] alu_vd,
    input  logic [39:0]       alu_reg_index,
    input  logic [3:0]        alu_done,
    output logic [VLEN-1:0]   vd,
    output logic              vd_valid,
    output logic              error
);

    localparam int CW = $clog2(VLEN) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_RUN, S_WAIT, S_DONE} state_t;

    // Lanes are limited both by the element count and by how many are instantiated.
    function automatic logic [1:0] f_nb(input logic [2:0] sew);
        int e;
        e = VLEN >> (int'(sew) + 3);
        if (e > (1 << NB_LANES)) e = 1 << NB_LANES;
        if (e >= 4)      return 2'd2;
        else if (e >= 2) return 2'd1;
        else             return 2'd0;
    endfunction

    function automatic int f_slice_log(input logic [2:0] sew);
        int s;
        s = int'(sew) + 3;
        return (s > LANE_WIDTH) ? LANE_WIDTH : s;
    endfunction

    function automatic int f_run_cycles(input logic [2:0] sew);
        return (VLEN >> f_slice_log(sew)) >> f_nb(sew);
    endfunction

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_mask;
    logic              r_ready;
    logic [5:0]        r_alu_opcode;
    logic [2:0]        r_alu_op_type;
    logic [2:0]        r_alu_vsew;
    logic [VLEN-1:0]   r_alu_vs1;
    logic [VLEN-1:0]   r_alu_vs2;
    logic [1:0]        r_alu_nb_lanes;
    logic [3:0]        r_alu_run;
    logic [VLEN-1:0]   r_vd;
    logic              r_vd_valid;
    logic              r_error;

    logic [1:0]        w_acc_nb;
    logic [3:0]        w_acc_mask;
    logic [CW-1:0]     w_acc_cnt;
    int                w_slice_w;
    logic [VLEN-1:0]   w_wmask;
    logic [VLEN-1:0]   w_vd_next;

    assign w_acc_nb   = f_nb(vsew);
    assign w_acc_mask = 4'((1 << (1 << w_acc_nb)) - 1);
    assign w_acc_cnt  = CW'(f_run_cycles(vsew));
    assign w_slice_w  = 1 << f_slice_log(r_alu_vsew);
    assign w_wmask    = ~({VLEN{1'b1}} << w_slice_w);

    // Merge each running lane's W-bit slice at its own reg_index; out-of-range indices are dropped.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_vd_next unassigned (no latch).
        w_vd_next = r_vd;
        for (int i = 0; i < 4; i++) begin
            if (r_alu_run[i] && (int'(alu_reg_index[i*10 +: 10]) <= VLEN - w_slice_w)) begin
                w_vd_next = (w_vd_next & ~(w_wmask << alu_reg_index[i*10 +: 10]))
                          | (alu_vd[i*VLEN +: VLEN] & (w_wmask << alu_reg_index[i*10 +: 10]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_mask         <= '0;
            r_ready        <= 1'b1;
            r_alu_opcode   <= '0;
            r_alu_op_type  <= '0;
            r_alu_vsew     <= '0;
            r_alu_vs1      <= '0;
            r_alu_vs2      <= '0;
            r_alu_nb_lanes <= '0;
            r_alu_run      <= '0;
            r_vd           <= '0;
            r_vd_valid     <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the same edge.
            r_error    <= 1'b0;
            r_vd_valid <= 1'b0;
            r_vd       <= w_vd_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (vsew >= 3'd4) begin
                            r_error <= 1'b1;
                        end else begin
                            r_alu_opcode   <= opcode;
                            r_alu_op_type  <= op_type;
                            r_alu_vsew     <= vsew;
                            r_alu_vs1      <= vs1_in;
                            r_alu_vs2      <= vs2_in;
                            r_alu_nb_lanes <= w_acc_nb;
                            r_mask         <= w_acc_mask;
                            r_cnt          <= w_acc_cnt;
                            r_vd           <= '0;
                            r_ready        <= 1'b0;
                            r_state        <= S_CFG;
                        end
                    end
                end
                S_CFG: begin
                    r_alu_run <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    r_alu_run <= r_mask;
                    if (|(alu_done & r_mask)) r_error <= 1'b1;
                    if (r_cnt <= CW'(1)) r_state <= S_WAIT;
                    else                 r_cnt   <= r_cnt - CW'(1);
                end
                S_WAIT: begin
                    r_alu_run <= '0;
                    if ((alu_done & r_mask) != r_mask) r_error <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_vd_valid <= 1'b1;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready        = r_ready;
    assign alu_opcode   = r_alu_opcode;
    assign alu_op_type  = r_alu_op_type;
    assign alu_vsew     = r_alu_vsew;
    assign alu_vs1      = r_alu_vs1;
    assign alu_vs2      = r_alu_vs2;
    assign alu_nb_lanes = r_alu_nb_lanes;
    assign alu_run      = r_alu_run;
    assign vd           = r_vd;
    assign vd_valid     = r_vd_valid;
    assign error        = r_error;

endmodule

// File: tb/tb_vec_lane_sched.sv
// Self-checking bench for vec_lane_sched: the bench plays the lane array and predicts the
// assembled result from the instruction semantics and the lane/slice/run-length rules.
module tb_vec_lane_sched;

    localparam int VLEN       = 128;
    localparam int LANE_WIDTH = 5;
    localparam int NB_LANES   = 1;

    localparam logic [5:0] VADD = 6'b000000;
    localparam logic [5:0] VAND = 6'b001001;
    localparam logic [5:0] VOR  = 6'b001010;
    localparam logic [5:0] VXOR = 6'b001011;
    localparam logic [2:0] VV   = 3'b001;
    localparam logic [2:0] VX   = 3'b010;
    localparam logic [2:0] VI   = 3'b100;

    logic              clk;
    logic              resetn;
    logic              start;
    logic              ready;
    logic [5:0]        opcode;
    logic [2:0]        op_type;
    logic [2:0]        vsew;
    logic [VLEN-1:0]   vs1_in;
    logic [VLEN-1:0]   vs2_in;
    logic [5:0]        alu_opcode;
    logic [2:0]        alu_op_type;
    logic [2:0]        alu_vsew;
    logic [VLEN-1:0]   alu_vs1;
    logic [VLEN-1:0]   alu_vs2;
    logic [1:0]        alu_nb_lanes;
    logic [3:0]        alu_run;
    logic [4*VLEN-1:0] alu_vd;
    logic [39:0]       alu_reg_index;
    logic [3:0]        alu_done;
    logic [VLEN-1:0]   vd;
    logic              vd_valid;
    logic              error;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [VLEN-1:0] hold_vd;

    vec_lane_sched #(
        .VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH), .NB_LANES(NB_LANES)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .ready(ready),
        .opcode(opcode), .op_type(op_type), .vsew(vsew),
        .vs1_in(vs1_in), .vs2_in(vs2_in),
        .alu_opcode(alu_opcode), .alu_op_type(alu_op_type), .alu_vsew(alu_vsew),
        .alu_vs1(alu_vs1), .alu_vs2(alu_vs2), .alu_nb_lanes(alu_nb_lanes),
        .alu_run(alu_run), .alu_vd(alu_vd), .alu_reg_index(alu_reg_index),
        .alu_done(alu_done), .vd(vd), .vd_valid(vd_valid), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Full-vector result of the instruction as the lanes collectively compute it.
    function automatic logic [VLEN-1:0] model_result(input logic [5:0] op, input logic [2:0] sew,
                                                     input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        logic [VLEN-1:0] r;
        logic            c;
        int              ew;
        r  = '0;
        c  = 1'b0;
        ew = 8 << sew;
        case (op)
            VAND:    r = a & b;
            VOR:     r = a | b;
            VXOR:    r = a ^ b;
            default: begin
                for (int i = 0; i < VLEN; i++) begin
                    if (i % ew == 0) c = 1'b0;
                    r[i] = a[i] ^ b[i] ^ c;
                    c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
                end
            end
        endcase
        return r;
    endfunction

    // fault: 0 none, 1 lanes withhold done in WAIT, 2 lane 0 raises done early in RUN.
    // abort_k > 0 pulls resetn low in that cycle after accept.
    task automatic run_op(input logic [5:0] op, input logic [2:0] ot, input logic [2:0] sew,
                          input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                          input int fault, input bit bad_idx, input int abort_k);
        int              e, nb, nl, s, w, n, total, s_bad, sl;
        logic [3:0]      mask;
        logic [VLEN-1:0] res, exp_vd, wm, sm, garbage;
        e = VLEN >> (sew + 3);
        if (e > (1 << NB_LANES)) e = 1 << NB_LANES;
        nb    = (e >= 4) ? 2 : (e >= 2) ? 1 : 0;
        nl    = 1 << nb;
        mask  = 4'((1 << nl) - 1);
        s     = (sew + 3 > LANE_WIDTH) ? LANE_WIDTH : sew + 3;
        w     = 1 << s;
        n     = (VLEN / w) / nl;
        total = VLEN / w;
        res   = model_result(op, sew, a, b);
        wm    = ~({VLEN{1'b1}} << w);
        exp_vd = res;
        s_bad  = -1;
        if (bad_idx) begin
            s_bad  = $urandom_range(0, total - 1);
            exp_vd = exp_vd & ~(wm << (s_bad * w));
        end

        @(negedge clk);
        opcode = op; op_type = ot; vsew = sew; vs1_in = a; vs2_in = b; start = 1'b1;
        for (int k = 0; k <= n + 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (abort_k > 0 && k == abort_k + 1) begin
                check("rst_run", alu_run, '0);
                check("rst_vd", vd, '0);
                check("rst_ready", ready, 1);
                check("rst_valid", vd_valid, 0);
                resetn  = 1'b1;
                hold_vd = '0;
                return;
            end
            if (k == 0) begin
                check("cfg_opcode", alu_opcode, op);
                check("cfg_op_type", alu_op_type, ot);
                check("cfg_vsew", alu_vsew, sew);
                check("cfg_vs1", alu_vs1, a);
                check("cfg_vs2", alu_vs2, b);
                check("cfg_nb_lanes", alu_nb_lanes, nb);
                check("vd_cleared", vd, '0);
            end
            if (k == 1) check("vs1_held", alu_vs1, a);
            check("alu_run", alu_run, (k >= 2 && k <= n + 1) ? mask : 4'd0);
            check("error", error, ((fault == 1 && k == n + 2) || (fault == 2 && k == 4)) ? 1 : 0);
            check("vd_valid", vd_valid, (k == n + 3) ? 1 : 0);
            check("ready", ready, (k >= n + 3) ? 1 : 0);
            if (k == n + 3) begin
                check("vd", vd, exp_vd);
                hold_vd = exp_vd;
            end
            if (k == n + 4) check("vd_hold", vd, exp_vd);

            if (k == 0) vs1_in = rand_vec();
            if (k == 2) begin start = 1'b1; vsew = 3'd0; end
            if (k == 3) start = 1'b0;
            if (abort_k > 0 && k == abort_k) resetn = 1'b0;

            // Lane stub drives the values seen during the remainder of cycle k.
            alu_done = 4'd0;
            if (k == n + 1 && fault != 1) alu_done = mask;
            if (fault == 2 && k == 3) alu_done = 4'b0001;
            for (int i = 0; i < 4; i++) begin
                garbage = rand_vec();
                alu_vd[i*VLEN +: VLEN]      = garbage;
                alu_reg_index[i*10 +: 10]   = 10'($urandom_range(0, VLEN - w));
                if (k >= 2 && k <= n + 1 && i < nl) begin
                    sl = (k - 2) * nl + i;
                    sm = wm << (sl * w);
                    alu_vd[i*VLEN +: VLEN] = (res & sm) | (garbage & ~sm);
                    alu_reg_index[i*10 +: 10] = (sl == s_bad) ? 10'($urandom_range(VLEN - w + 1, 1023))
                                                              : 10'(sl * w);
                end
            end
        end
    endtask

    task automatic bad_sew();
        @(negedge clk);
        opcode = VAND; op_type = VV; vsew = 3'd5; vs1_in = rand_vec(); vs2_in = rand_vec(); start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            check("badsew_error", error, (k == 0) ? 1 : 0);
            check("badsew_run", alu_run, '0);
            check("badsew_ready", ready, 1);
            check("badsew_vd", vd, hold_vd);
        end
    endtask

    initial begin
        logic [VLEN-1:0] x;
        logic [5:0]      ops [4];
        logic [2:0]      ots [3];
        ops = '{VADD, VAND, VOR, VXOR};
        ots = '{VV, VX, VI};
        resetn = 1'b0; start = 1'b0; opcode = '0; op_type = '0; vsew = '0;
        vs1_in = '0; vs2_in = '0; alu_vd = '0; alu_reg_index = '0; alu_done = '0; hold_vd = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_run", alu_run, '0);
        check("reset_vd", vd, '0);
        check("reset_valid", vd_valid, 0);
        check("reset_error", error, 0);
        check("reset_vs1", alu_vs1, '0);
        check("reset_opcode", alu_opcode, '0);
        check("reset_nb", alu_nb_lanes, '0);
        resetn = 1'b1;

        run_op(VAND, VV, 3'd0, {VLEN{1'b1}}, 128'h8765432112345678beefbeefabcdabcd, 0, 0, 0);
        x = rand_vec();
        run_op(VXOR, VV, 3'd2, x, x, 0, 0, 0);
        run_op(VOR, VV, 3'd3, '0, rand_vec(), 0, 0, 0);
        bad_sew();
        run_op(VADD, VX, 3'd1, rand_vec(), rand_vec(), 1, 0, 0);
        run_op(VAND, VV, 3'd0, rand_vec(), rand_vec(), 2, 0, 0);
        run_op(VXOR, VV, 3'd0, rand_vec(), rand_vec(), 0, 0, 4);
        run_op(VOR, VV, 3'd0, rand_vec(), rand_vec(), 0, 0, 0);
        run_op(VADD, VV, 3'd2, rand_vec(), rand_vec(), 0, 1, 0);

        for (int t = 0; t < 12; t++) begin
            run_op(ops[$urandom_range(0, 3)], ots[$urandom_range(0, 2)], 3'($urandom_range(0, 3)),
                   rand_vec(), rand_vec(), 0, bit'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
